// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin burst scheduler driving an 8:1 mux select; MUX8_RR_SCHED_MASK_EN adds chan_mask
module mux8_rr_sched #(
  parameter int BURST_LEN = 1,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
`ifdef MUX8_RR_SCHED_MASK_EN
  input  logic [7:0] chan_mask,
`endif
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic       out_valid,
  output logic [7:0] grant,
  output logic       busy
);
  typedef enum logic {IDLE, SERVE} state_t;
  state_t state;
  logic [2:0] ptr, base, win, idx;
  logic [CNT_W-1:0] cnt;
  logic [7:0] elig;
  logic found, hs, cont;
  // eligible requests, handshake, burst continuation and grant pulse
  always_comb begin
`ifdef MUX8_RR_SCHED_MASK_EN
    elig = req & ~chan_mask;
`else
    elig = req;
`endif
    hs = out_valid && out_ready;
    cont = elig[sel] && (int'(cnt) + 1 < BURST_LEN);
    grant = hs ? 8'd1 << sel : 8'd0;
  end
  // first eligible channel scanning upward from the one after the last served
  always_comb begin
    base = (state == SERVE) ? sel : ptr;
    win = 3'd0;
    found = 1'b0;
    idx = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = base + 3'(i);
      if (!found && elig[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // IDLE/SERVE sequencing; a presented transfer is held until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel <= 3'd0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      ptr <= 3'd7;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= SERVE;
        sel <= win;
        out_valid <= 1'b1;
        cnt <= '0;
        busy <= 1'b0;
      end
    end else if (hs) begin
      if (cont) begin
        cnt <= cnt + 1'b1;
        busy <= 1'b1;
      end else begin
        ptr <= sel;
        cnt <= '0;
        busy <= 1'b0;
        sel <= found ? win : sel;
        out_valid <= found;
        state <= found ? SERVE : IDLE;
      end
    end
  end
endmodule

// File: doc/mux8_rr_sched.md
Name: mux8_rr_sched

Overview:
- Upstream control stage for the 8-input, 8-bit, 3-bit-select mux.
- Arbitrates among 8 requesting sources using round-robin and drives the mux select.
- Presents the selected transfer downstream with a valid/ready handshake, and returns a one-cycle grant pulse to the served source.
- Supports bursts: a winning channel may keep the mux for up to BURST_LEN consecutive transfers.

Parameters:
- BURST_LEN, 1, maximum consecutive handshakes per winner before forced rotation; legal range 1..16.
- CNT_W, 4, width of the burst counter; must satisfy 2**CNT_W >= BURST_LEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  per-channel request; bit i requests mux input d<i>.
- out_ready  input  1  downstream consumer accepts the current mux output.
- sel  output  3  registered mux select; drives the mux sel input.
- out_valid  output  1  registered; the mux output on sel is a valid transfer.
- grant  output  8  one-hot combinational pulse = (1<<sel) when out_valid && out_ready; else 0.
- busy  output  1  registered; high while the current winner is inside a burst (burst count > 0).

Behaviour:
- Reset values: sel=0, out_valid=0, busy=0, grant=0, last-served pointer=7, burst count=0. This gives channel 0 top priority after reset.
- Reset is asynchronous: asserting rst mid-burst or mid-stall clears all state immediately. After release, no out_valid for at least 1 cycle.
- States: IDLE and SERVE.
- IDLE:
  - out_valid=0.
  - If req != 0, the winner is the first set bit scanning upward from (pointer+1) mod 8, wrapping 7->0.
  - Next edge: sel=winner, out_valid=1, state=SERVE, burst count=0.
  - Latency from req to out_valid is 1 cycle.
- SERVE, out_valid && !out_ready (stall):
  - sel, out_valid and burst count are held.
  - Deassertion of req[sel] during a stall is ignored; a committed transfer is never withdrawn.
- SERVE, handshake with burst continuation:
  - Condition: req[sel] still high and burst count < BURST_LEN-1.
  - sel is kept, out_valid stays 1, burst count increments, busy=1.
- SERVE, handshake otherwise:
  - pointer=sel and burst count=0.
  - If any request is pending, the next winner is arbitrated in the same cycle using the updated pointer. The served channel becomes lowest priority; its req bit is still considered and wins only if it is the sole requester.
  - The next edge loads the new sel with out_valid=1. Back-to-back transfers have no bubble.
  - If req == 0, go to IDLE and set out_valid=0.
- grant is asserted exactly in each handshake cycle, one bit only, matching sel.
- sel never changes while out_valid=1 && out_ready=0.
- BURST_LEN=1 degenerates to pure round-robin, one transfer per winner.

Optional Feature:
- Macro: MUX8_RR_SCHED_MASK_EN.
- When defined:
  - Adds input port chan_mask (8 bits). Arbitration uses req & ~chan_mask.
  - A masked channel cannot win a new arbitration and cannot continue a burst.
  - A transfer already presented (out_valid=1) completes even if its channel is masked during a stall.
- When undefined: no chan_mask port; arbitration uses req directly.

Test Plan:
- Reset then req=8'b0000_0001 with out_ready=1 -> 1 cycle later sel=0 and out_valid=1. In the handshake cycle grant=8'h01; the following cycle sel is still 0 because the pointer rotated and channel 0 is the only requester.
- req=8'hFF, out_ready=1, BURST_LEN=1 -> sel sequence 0,1,2,...,7,0 on consecutive cycles. grant walks 01,02,04,...,80. No bubbles.
- req=8'b1000_0100, out_ready held 0 for 5 cycles after sel=2 -> sel=2 and out_valid=1 held all 5 cycles with grant=0. Release out_ready -> grant=8'h04, then sel=7.
- BURST_LEN=3, req=8'b0000_0011, out_ready=1 -> sel=0 for 3 handshakes with busy=1 on the 2nd and 3rd, then sel=1 for 3 handshakes. If req[0] drops after its 1st handshake, rotate early to sel=1.
- rst asserted while sel=5, out_valid=1, burst count=1 -> same-instant out_valid=0, sel=0, busy=0. After release with req=8'h20, sel=5 is reached via a fresh arbitration.
- With MUX8_RR_SCHED_MASK_EN: req=8'hFF, chan_mask=8'h0F -> only sel=4,5,6,7 appear. Masking channel 5 while it is stalled still completes that transfer on out_ready.
